pch_pwr_req_ctrl: RTL and testbench
===================================

# pch_pwr_req_ctrl

Initiator side of the PCH power enable/PWRGD handshake. It drives the enable input of the PCH VR power sequencer and supervises its `PCH_PWRGD`, `PCH_PWR_FLT` and `RSMRST_N` responses against timeouts. It reports a ready/fault status to the master sequencer. It sits between the S5 power-request logic and the PCH sequencer, all on the 2 MHz CPLD clock.

## Interface
Parameters:
- `T_PWRGD_TO`, 200000: max cycles in ST_REQ_ON waiting for `iPCH_PWRGD` (100 ms).
- `T_RSMRST_TO`, 200000: max cycles in ST_WAIT_RSMRST waiting for `iRST_RSMRST_N`.
- `T_OFF_TO`, 100000: max cycles in ST_REQ_OFF waiting for both inputs low (50 ms).
- `T_RETRY_GAP`, 2000: minimum off time before a retry (1 ms).
- `MAX_RETRY`, 3: retries allowed per request (1..3).

Ports (reset iRst_n, asynchronous, active-low; clock iClk):
- `iClk` in 1: 2 MHz clock.
- `iRst_n` in 1: async active-low reset.
- `iPWR_REQ` in 1: level request for PCH power (S5 entry).
- `iFM_PCH_PRSNT_N` in 1: PCH present, active-low.
- `iPCH_PWRGD` in 1: all PCH VRs good, from sequencer.
- `iPCH_PWR_FLT` in 1: sequencer VR fault, sticky at source.
- `iRST_RSMRST_N` in 1: RSMRST# from sequencer.
- `oPCH_PWR_EN` out 1: enable to sequencer.
- `oPCH_READY` out 1: PCH powered and out of RSMRST.
- `oPCH_FAULT` out 1: sticky, VR fault seen while enabled.
- `oPCH_TIMEOUT` out 1: sticky, handshake timeout exhausted.
- `oRETRY_CNT` out 2: retries consumed in current request.
- `oSTATE` out 3: state encoding, for debug.

## Operation
- States:
  - ST_IDLE=0
  - ST_REQ_ON=1
  - ST_WAIT_RSMRST=2
  - ST_ON=3
  - ST_REQ_OFF=4
  - ST_RETRY_WAIT=5
  - ST_FAULT=6
  - Other codes go to ST_IDLE.
- ST_IDLE: if `iPWR_REQ` high and `iFM_PCH_PRSNT_N` low, go to ST_REQ_ON and clear the retry count.
- ST_REQ_ON: if `iPCH_PWRGD`, go to ST_WAIT_RSMRST. If the timeout expires, the timeout path applies.
- ST_WAIT_RSMRST: if `iRST_RSMRST_N`, go to ST_ON. If `iPCH_PWRGD` drops or the timeout expires, the timeout path applies.
- ST_ON: if `iPCH_PWRGD` drops while `iPCH_PWR_FLT` is low, go to ST_REQ_OFF.
- In ST_REQ_ON, ST_WAIT_RSMRST and ST_ON, priority is:
  - `iPCH_PWR_FLT` goes to ST_FAULT and sets `oPCH_FAULT`.
  - Else `iPWR_REQ` low goes to ST_REQ_OFF.
  - Else the state-specific rule.
- ST_REQ_OFF: when `iPCH_PWRGD` and `iRST_RSMRST_N` are both low, go to ST_IDLE. If the timeout expires, go to ST_FAULT and set `oPCH_TIMEOUT`.
- Timeout path (without retry): go to ST_FAULT and set `oPCH_TIMEOUT`.
- ST_FAULT: terminal. Only `iRst_n` exits it.
- Timeout counter:
  - One shared counter; cleared on every state change; saturates.
  - A timeout fires on the cycle the count equals T−1.
  - If the success condition and the timeout occur in the same cycle, success wins.
- `oPCH_PWR_EN`: high exactly in states 1, 2 and 3.
- `oPCH_READY`: high exactly in state 3.

## Timing
- All outputs are registered and decoded from the next state. They change on the same edge as the state.
- Reset values:
  - `oPCH_PWR_EN`=0, `oPCH_READY`=0
  - `oPCH_FAULT`=0, `oPCH_TIMEOUT`=0
  - `oRETRY_CNT`=0, `oSTATE`=0
- `iPWR_REQ` sampled high at edge N: `oPCH_PWR_EN`=1 after edge N.
- `iRST_RSMRST_N` sampled high at edge M: `oPCH_READY`=1 after edge M.
- Request drop or fault sampled at edge K: `oPCH_PWR_EN`=0 after edge K.
- Inputs are synchronous to iClk. Synchronizers are external.
- An asynchronous reset mid-sequence drops the enable immediately. The sequencer handles the resulting VR power-down.

## Configuration
- Macro `PCH_PWR_RETRY_EN`.
- When defined, a timeout from ST_REQ_ON or ST_WAIT_RSMRST proceeds as follows:
  - If `oRETRY_CNT` < MAX_RETRY: increment `oRETRY_CNT` and go to ST_RETRY_WAIT, with enable low.
  - ST_RETRY_WAIT leaves to ST_REQ_ON after both conditions hold: `iPCH_PWRGD` low, and at least T_RETRY_GAP cycles in the state.
  - If `iPWR_REQ` drops, ST_RETRY_WAIT leaves to ST_IDLE instead.
  - If `oRETRY_CNT` = MAX_RETRY: go to ST_FAULT and set `oPCH_TIMEOUT`.
- When not defined, ST_RETRY_WAIT is absent, `oRETRY_CNT` is tied 0, and any timeout goes straight to ST_FAULT.

## Structure
- Shared package: the state localparams, the default timeout constants, and `CNT_W` (18 bits, sized for the largest T).
- One sub-module, `pch_req_timer`: a loadable, saturating cycle counter with a clear input and a compare-equal output. The FSM selects which T is compared.

## Test plan
Bench parameters: T_PWRGD_TO=10, T_RSMRST_TO=10, T_OFF_TO=10, T_RETRY_GAP=4.
- **Normal power-up.** Request high, PWRGD at +3 cycles, RSMRST at +6 cycles → EN at +1, READY at +7, no flags set.
- **Timeout, no macro.** Request high, PWRGD never asserted → ST_FAULT after 10 cycles in ST_REQ_ON, TIMEOUT=1, EN=0.
- **Timeout, macro defined, MAX_RETRY=2.** PWRGD never asserted → two retries, each with EN low for ≥4 cycles, `oRETRY_CNT`=2, then FAULT with TIMEOUT=1.
- **Fault while on.** In ST_ON, FLT pulses high with request still high → EN=0 next edge, FAULT=1 and stays set; request toggling does not leave ST_FAULT.
- **Normal power-down.** In ST_ON, request low; PWRGD and RSMRST drop 3 cycles later → ST_IDLE, no flags set.
- **Simultaneous events and reset.**
  - PWRGD rises on the cycle the count reaches 9 → ST_WAIT_RSMRST, no timeout.
  - Async reset asserted in ST_WAIT_RSMRST → all outputs 0 immediately.

Source files
------------

// File: rtl/pch_pwr_req_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pch_pwr_req_ctrl_pkg
// Shared definitions for the PCH power enable / PWRGD handshake controller:
// state encoding, default handshake timeouts (in 2 MHz clock cycles) and the
// width of the shared timeout counter.
// ----------------------------------------------------------------------------
package pch_pwr_req_ctrl_pkg;

  // Counter width; sized to hold the largest default timeout (200000 cycles).
  localparam int CNT_W = 18;

  // Default timeouts at 2 MHz.
  localparam int T_PWRGD_TO_DEF  = 200000;  // 100 ms
  localparam int T_RSMRST_TO_DEF = 200000;  // 100 ms
  localparam int T_OFF_TO_DEF    = 100000;  // 50 ms
  localparam int T_RETRY_GAP_DEF = 2000;    // 1 ms
  localparam int MAX_RETRY_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ_ON      = 3'd1,
    ST_WAIT_RSMRST = 3'd2,
    ST_ON          = 3'd3,
    ST_REQ_OFF     = 3'd4,
    ST_RETRY_WAIT  = 3'd5,
    ST_FAULT       = 3'd6
  } state_t;

endpackage

// File: rtl/pch_req_timer.sv
// ----------------------------------------------------------------------------
// pch_req_timer
// Cycle counter shared by all handshake states. Counts cycles spent in the
// current state, clears on iClr, and saturates once it reaches iLimit so a
// held oEq also means "at least iLimit+1 cycles elapsed".
// Ports:
//   iClk, iRst_n : clock, async active-low reset
//   iClr         : synchronous clear (asserted on every state change)
//   iLimit       : compare / saturation value (T-1 for the active state)
//   oEq          : count equals iLimit
// ----------------------------------------------------------------------------
module pch_req_timer
  import pch_pwr_req_ctrl_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClr,
  input  logic [CNT_W-1:0] iLimit,
  output logic             oEq
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (cnt != iLimit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign oEq = (cnt == iLimit);

endmodule

// File: rtl/pch_pwr_req_ctrl.sv
// ----------------------------------------------------------------------------
// pch_pwr_req_ctrl
// Initiator side of the PCH power enable / PWRGD handshake. Drives the PCH VR
// sequencer enable and supervises PWRGD, PWR_FLT and RSMRST# against timeouts,
// reporting ready / fault status to the master sequencer.
//
// Optional feature: define PCH_PWR_RETRY_EN to retry a timed-out power-up
// (from ST_REQ_ON / ST_WAIT_RSMRST) up to MAX_RETRY times, with the enable
// held low for at least T_RETRY_GAP cycles between attempts.
//
// Ports:
//   iClk, iRst_n     : 2 MHz clock, async active-low reset
//   iPWR_REQ         : level request for PCH power
//   iFM_PCH_PRSNT_N  : PCH present (active-low)
//   iPCH_PWRGD       : all PCH VRs good
//   iPCH_PWR_FLT     : sequencer VR fault (sticky at source)
//   iRST_RSMRST_N    : RSMRST# from sequencer
//   oPCH_PWR_EN      : enable to sequencer (states 1..3)
//   oPCH_READY       : powered and out of RSMRST (state 3)
//   oPCH_FAULT       : sticky, VR fault seen while enabled
//   oPCH_TIMEOUT     : sticky, handshake timeout exhausted
//   oRETRY_CNT       : retries consumed in current request
//   oSTATE           : state encoding, for debug
// All outputs are registered and decoded from the next state.
// ----------------------------------------------------------------------------
module pch_pwr_req_ctrl
  import pch_pwr_req_ctrl_pkg::*;
#(
  parameter int T_PWRGD_TO  = T_PWRGD_TO_DEF,
  parameter int T_RSMRST_TO = T_RSMRST_TO_DEF,
  parameter int T_OFF_TO    = T_OFF_TO_DEF,
  parameter int T_RETRY_GAP = T_RETRY_GAP_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iPWR_REQ,
  input  logic       iFM_PCH_PRSNT_N,
  input  logic       iPCH_PWRGD,
  input  logic       iPCH_PWR_FLT,
  input  logic       iRST_RSMRST_N,
  output logic       oPCH_PWR_EN,
  output logic       oPCH_READY,
  output logic       oPCH_FAULT,
  output logic       oPCH_TIMEOUT,
  output logic [1:0] oRETRY_CNT,
  output logic [2:0] oSTATE
);

`ifdef PCH_PWR_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t           state, nextState;
  logic [CNT_W-1:0] limit;
  logic             tmoHit;
  logic             tmoPath;
  logic             clrRetry, incRetry, setFault, setTmo;
  logic [1:0]       retryCnt;

  // Compare value for the shared timer; depends on current state only so it
  // stays free of the next-state logic that consumes tmoHit.
  always_comb begin
    limit = '1;
    case (state)
      ST_REQ_ON:      limit = CNT_W'(T_PWRGD_TO - 1);
      ST_WAIT_RSMRST: limit = CNT_W'(T_RSMRST_TO - 1);
      ST_REQ_OFF:     limit = CNT_W'(T_OFF_TO - 1);
      ST_RETRY_WAIT:  limit = CNT_W'(T_RETRY_GAP - 1);
      default:        limit = '1;
    endcase
  end

  pch_req_timer uTimer (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (nextState != state),
    .iLimit (limit),
    .oEq    (tmoHit)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    tmoPath   = 1'b0;
    clrRetry  = 1'b0;
    incRetry  = 1'b0;
    setFault  = 1'b0;
    setTmo    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (iPWR_REQ && !iFM_PCH_PRSNT_N) begin
          nextState = ST_REQ_ON;
          clrRetry  = 1'b1;
        end
      end

      ST_REQ_ON, ST_WAIT_RSMRST, ST_ON: begin
        if (iPCH_PWR_FLT) begin
          nextState = ST_FAULT;
          setFault  = 1'b1;
        end else if (!iPWR_REQ) begin
          nextState = ST_REQ_OFF;
        end else if (state == ST_REQ_ON) begin
          // Success is tested before the timeout so it wins a same-cycle tie.
          if (iPCH_PWRGD)  nextState = ST_WAIT_RSMRST;
          else if (tmoHit) tmoPath   = 1'b1;
        end else if (state == ST_WAIT_RSMRST) begin
          if (iRST_RSMRST_N)                nextState = ST_ON;
          else if (!iPCH_PWRGD || tmoHit)   tmoPath   = 1'b1;
        end else begin
          if (!iPCH_PWRGD) nextState = ST_REQ_OFF;
        end
      end

      ST_REQ_OFF: begin
        if (!iPCH_PWRGD && !iRST_RSMRST_N) begin
          nextState = ST_IDLE;
        end else if (tmoHit) begin
          nextState = ST_FAULT;
          setTmo    = 1'b1;
        end
      end

`ifdef PCH_PWR_RETRY_EN
      ST_RETRY_WAIT: begin
        // The timer saturates at T_RETRY_GAP-1, so tmoHit stays high once the
        // minimum off time has elapsed while PWRGD is still draining.
        if (!iPWR_REQ)                   nextState = ST_IDLE;
        else if (!iPCH_PWRGD && tmoHit)  nextState = ST_REQ_ON;
      end
`endif

      ST_FAULT: nextState = ST_FAULT;

      default: nextState = ST_IDLE;
    endcase

    if (tmoPath) begin
      if (RETRY_EN && (retryCnt < 2'(MAX_RETRY))) begin
        nextState = ST_RETRY_WAIT;
        incRetry  = 1'b1;
      end else begin
        nextState = ST_FAULT;
        setTmo    = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= ST_IDLE;
      retryCnt     <= '0;
      oPCH_PWR_EN  <= 1'b0;
      oPCH_READY   <= 1'b0;
      oPCH_FAULT   <= 1'b0;
      oPCH_TIMEOUT <= 1'b0;
    end else begin
      state        <= nextState;
      if (clrRetry)      retryCnt <= '0;
      else if (incRetry) retryCnt <= retryCnt + 2'd1;
      oPCH_PWR_EN  <= (nextState == ST_REQ_ON) || (nextState == ST_WAIT_RSMRST) ||
                      (nextState == ST_ON);
      oPCH_READY   <= (nextState == ST_ON);
      oPCH_FAULT   <= oPCH_FAULT | setFault;
      oPCH_TIMEOUT <= oPCH_TIMEOUT | setTmo;
    end
  end

  assign oRETRY_CNT = retryCnt;
  assign oSTATE     = state;

endmodule

// File: tb/tb_pch_pwr_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pch_pwr_req_ctrl
// Directed bench for pch_pwr_req_ctrl with short timeouts. Each step queues
// the expected output vector {EN, READY, FAULT, TIMEOUT, RETRY_CNT, STATE}
// as inputs are driven and checks it 1 ns after the next rising edge.
// ----------------------------------------------------------------------------
module tb_pch_pwr_req_ctrl;
  import pch_pwr_req_ctrl_pkg::*;

  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       req = 1'b0, prsntN = 1'b0, pwrgd = 1'b0, flt = 1'b0, rsm = 1'b0;
  logic       en, ready, fault, tmo;
  logic [1:0] retry;
  logic [2:0] st;

  int nAssert = 0;
  int nFail   = 0;

  logic [8:0] expQ[$];
  string      tagQ[$];

  always #5 clk = ~clk;

  pch_pwr_req_ctrl #(
    .T_PWRGD_TO  (10),
    .T_RSMRST_TO (10),
    .T_OFF_TO    (10),
    .T_RETRY_GAP (4),
    .MAX_RETRY   (MAXR)
  ) dut (
    .iClk            (clk),
    .iRst_n          (rstN),
    .iPWR_REQ        (req),
    .iFM_PCH_PRSNT_N (prsntN),
    .iPCH_PWRGD      (pwrgd),
    .iPCH_PWR_FLT    (flt),
    .iRST_RSMRST_N   (rsm),
    .oPCH_PWR_EN     (en),
    .oPCH_READY      (ready),
    .oPCH_FAULT      (fault),
    .oPCH_TIMEOUT    (tmo),
    .oRETRY_CNT      (retry),
    .oSTATE          (st)
  );

  wire [8:0] obs = {en, ready, fault, tmo, retry, st};

  // Expected vector: EN in states 1..3, READY only in state 3.
  function automatic logic [8:0] mk(state_t s, bit f, bit t, logic [1:0] r);
    logic e, rd;
    e  = (s == ST_REQ_ON) || (s == ST_WAIT_RSMRST) || (s == ST_ON);
    rd = (s == ST_ON);
    return {e, rd, f, t, r, 3'(s)};
  endfunction

  task automatic check(string tag, logic [8:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock step: queue expectation, advance, compare away from the edge.
  task automatic cyc(string tag, state_t s, bit f = 0, bit t = 0, logic [1:0] r = 2'd0);
    logic [8:0] e;
    string      tg;
    expQ.push_back(mk(s, f, t, r));
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    e  = expQ.pop_front();
    tg = tagQ.pop_front();
    check(tg, e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    req = 0; pwrgd = 0; flt = 0; rsm = 0; prsntN = 0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic powerUp();
    req = 1;   cyc("pu_req", ST_REQ_ON);
    pwrgd = 1; cyc("pu_pwrgd", ST_WAIT_RSMRST);
    rsm = 1;   cyc("pu_rsm", ST_ON);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset", 9'd0);
    @(negedge clk);
    rstN = 1'b1;

    // PCH absent: request ignored
    prsntN = 1; req = 1;
    cyc("absent0", ST_IDLE);
    cyc("absent1", ST_IDLE);
    req = 0; prsntN = 0;
    cyc("absent2", ST_IDLE);

    // Normal power-up: EN after first edge, PWRGD at +3, RSMRST at +6
    req = 1;   cyc("up_en", ST_REQ_ON);
    cyc("up_w1", ST_REQ_ON);
    cyc("up_w2", ST_REQ_ON);
    pwrgd = 1; cyc("up_pwrgd", ST_WAIT_RSMRST);
    cyc("up_w3", ST_WAIT_RSMRST);
    cyc("up_w4", ST_WAIT_RSMRST);
    rsm = 1;   cyc("up_ready", ST_ON);
    cyc("up_hold", ST_ON);

    // Normal power-down: PWRGD/RSMRST drop 3 cycles after request low
    req = 0;   cyc("dn_off", ST_REQ_OFF);
    cyc("dn_w1", ST_REQ_OFF);
    cyc("dn_w2", ST_REQ_OFF);
    pwrgd = 0; rsm = 0;
    cyc("dn_idle", ST_IDLE);

    // PWRGD arrives on the cycle the count reaches 9: success wins
    req = 1;   cyc("race_req", ST_REQ_ON);
    for (int i = 0; i < 9; i++) cyc("race_wait", ST_REQ_ON);
    pwrgd = 1; cyc("race_pwrgd", ST_WAIT_RSMRST);

    // Async reset in ST_WAIT_RSMRST drops everything immediately
    #2;
    rstN = 1'b0;
    #1;
    check("async_rst", 9'd0);
    doReset();

    // PWRGD never arrives
    req = 1;   cyc("tmo_req", ST_REQ_ON);
    for (int i = 0; i < 9; i++) cyc("tmo_wait", ST_REQ_ON);
`ifdef PCH_PWR_RETRY_EN
    for (int a = 1; a <= MAXR; a++) begin
      cyc("retry_enter", ST_RETRY_WAIT, 0, 0, 2'(a));
      for (int i = 0; i < 3; i++) cyc("retry_gap", ST_RETRY_WAIT, 0, 0, 2'(a));
      cyc("retry_reon", ST_REQ_ON, 0, 0, 2'(a));
      for (int i = 0; i < 9; i++) cyc("retry_wait", ST_REQ_ON, 0, 0, 2'(a));
    end
    cyc("retry_fault", ST_FAULT, 0, 1, 2'(MAXR));
    req = 0;   cyc("retry_stuck", ST_FAULT, 0, 1, 2'(MAXR));
`else
    cyc("tmo_fault", ST_FAULT, 0, 1);
    req = 0;   cyc("tmo_stuck", ST_FAULT, 0, 1);
`endif
    doReset();
    cyc("post_rst", ST_IDLE);

    // VR fault while on; ST_FAULT is terminal
    powerUp();
    flt = 1;   cyc("flt_on", ST_FAULT, 1, 0);
    flt = 0; req = 0;
    cyc("flt_req0", ST_FAULT, 1, 0);
    req = 1;   cyc("flt_req1", ST_FAULT, 1, 0);
    cyc("flt_hold", ST_FAULT, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  // Global bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
